// File: rtl/mult_pkg.sv
// Shared types and constants for the sequential 8x8 multiplier controller.
package mult_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CALC  = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam logic [1:0] SHIFT_0 = 2'b00;
  localparam logic [1:0] SHIFT_4 = 2'b01;
  localparam logic [1:0] SHIFT_8 = 2'b10;

  // Shift amount for each partial product: lo*lo unshifted, cross terms by 4, hi*hi by 8.
  function automatic logic [1:0] shift_for_cnt(input logic [1:0] cnt);
    logic [1:0] sc;
    case (cnt)
      2'd0:    sc = SHIFT_0;
      2'd3:    sc = SHIFT_8;
      default: sc = SHIFT_4;
    endcase
    return sc;
  endfunction

endpackage

// File: rtl/nibble_mult_4x4.sv
// Combinational 4-bit x 4-bit unsigned multiplier producing an 8-bit product.
module nibble_mult_4x4 (
  input  logic [3:0] a,
  input  logic [3:0] b,
  output logic [7:0] p
);

  // Operands widened so the multiply is evaluated at full product width.
  always_comb begin
    p = {4'h0, a} * {4'h0, b};
  end

endmodule

// File: rtl/mult8x8_seq_ctrl.sv
// Sequential 8x8 unsigned multiplier controller/accumulator around an external left_shifter.
// Optional build macro MULT_PIPE_REG_EN: registers shift_out before accumulation and adds a DRAIN state.
module mult8x8_seq_ctrl
  import mult_pkg::*;
#(
  parameter int unsigned HOLD_DONE = 0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [7:0]  dataa,
  input  logic [7:0]  datab,
  output logic [7:0]  shift_in,
  output logic [1:0]  shift_cntrl,
  input  logic [15:0] shift_out,
  output logic [15:0] product,
  output logic        busy,
  output logic        done
);

  state_t      state_q, state_d;
  logic [1:0]  cnt_q;
  logic [7:0]  a_q, b_q;
  logic [15:0] product_q;
  logic        done_hold_q;
  logic        start_acc;
  logic        acc_en;
  logic [15:0] add_val;
  logic [3:0]  nib_a, nib_b;
  logic [7:0]  nib_p;

`ifdef MULT_PIPE_REG_EN
  logic [15:0] pipe_q;
`endif

  // Select operand nibbles for the partial product of the current count.
  always_comb begin
    nib_a = '0;
    nib_b = '0;
    case (cnt_q)
      2'd0: begin nib_a = a_q[3:0]; nib_b = b_q[3:0]; end
      2'd1: begin nib_a = a_q[3:0]; nib_b = b_q[7:4]; end
      2'd2: begin nib_a = a_q[7:4]; nib_b = b_q[3:0]; end
      default: begin nib_a = a_q[7:4]; nib_b = b_q[7:4]; end
    endcase
  end

  nibble_mult_4x4 u_nib (
    .a (nib_a),
    .b (nib_b),
    .p (nib_p)
  );

  // Next-state logic and control/status outputs.
  always_comb begin
    state_d     = state_q;
    start_acc   = 1'b0;
    acc_en      = 1'b0;
    shift_in    = '0;
    shift_cntrl = SHIFT_0;
    busy        = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          start_acc = 1'b1;
          state_d   = CALC;
        end
      end
      CALC: begin
        busy        = 1'b1;
        acc_en      = 1'b1;
        shift_in    = nib_p;
        shift_cntrl = shift_for_cnt(cnt_q);
        if (cnt_q == 2'd3) begin
`ifdef MULT_PIPE_REG_EN
          state_d = DRAIN;
`else
          state_d = DONE;
`endif
        end
      end
      DRAIN: begin
        busy    = 1'b1;
`ifdef MULT_PIPE_REG_EN
        acc_en  = 1'b1;
`endif
        state_d = DONE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

`ifdef MULT_PIPE_REG_EN
  // With the pipe register, each accumulation adds the previous cycle's shifter result.
  always_comb begin
    add_val = pipe_q;
  end
`else
  // Without the pipe register, the shifter result is added in the same cycle.
  always_comb begin
    add_val = shift_out;
  end
`endif

  // State, operand, count and accumulator registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      a_q         <= '0;
      b_q         <= '0;
      product_q   <= '0;
      done_hold_q <= 1'b0;
`ifdef MULT_PIPE_REG_EN
      pipe_q      <= '0;
`endif
    end else begin
      state_q <= state_d;
      if (start_acc) begin
        a_q         <= dataa;
        b_q         <= datab;
        product_q   <= '0;
        cnt_q       <= '0;
        done_hold_q <= 1'b0;
`ifdef MULT_PIPE_REG_EN
        pipe_q      <= '0;
`endif
      end else begin
        if (acc_en) begin
          product_q <= product_q + add_val;
        end
        if (state_q == CALC) begin
          cnt_q <= cnt_q + 2'd1;
`ifdef MULT_PIPE_REG_EN
          pipe_q <= shift_out;
`endif
        end
        if (state_q == DONE) begin
          done_hold_q <= 1'b1;
        end
      end
    end
  end

  // Completion flag: pulse in DONE, optionally sticky until the next accepted start.
  always_comb begin
    done    = (state_q == DONE) || ((HOLD_DONE != 0) && done_hold_q);
    product = product_q;
  end

endmodule

// File: tb/tb_mult8x8_seq_ctrl.sv
// Self-checking bench for mult8x8_seq_ctrl with a behavioural left shifter in the loop.
module tb_mult8x8_seq_ctrl;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [7:0]  dataa;
  logic [7:0]  datab;
  logic [7:0]  shift_in;
  logic [1:0]  shift_cntrl;
  logic [15:0] shift_out;
  logic [15:0] product;
  logic        busy;
  logic        done;

  int unsigned checks   = 0;
  int unsigned failures = 0;
  logic [15:0] sb[$];

`ifdef MULT_PIPE_REG_EN
  localparam int unsigned LAT = 6;
`else
  localparam int unsigned LAT = 5;
`endif

  mult8x8_seq_ctrl #(.HOLD_DONE(0)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .dataa       (dataa),
    .datab       (datab),
    .shift_in    (shift_in),
    .shift_cntrl (shift_cntrl),
    .shift_out   (shift_out),
    .product     (product),
    .busy        (busy),
    .done        (done)
  );

  // Behavioural left shifter: zero-extend and shift left by 4*shift_cntrl.
  always_comb begin
    shift_out = {8'h00, shift_in} << {shift_cntrl, 2'b00};
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drive one operation, check the partial-product sequence, latency and result.
  task automatic run_op(input logic [7:0] a, input logic [7:0] b,
                        input bit hold, input logic [7:0] na, input logic [7:0] nb);
    logic [7:0]  exp_si[4];
    logic [1:0]  exp_sc[4];
    logic [15:0] exp_p;
    int unsigned n;
    bit          seen;
    exp_si[0] = {4'h0, a[3:0]} * {4'h0, b[3:0]};
    exp_si[1] = {4'h0, a[3:0]} * {4'h0, b[7:4]};
    exp_si[2] = {4'h0, a[7:4]} * {4'h0, b[3:0]};
    exp_si[3] = {4'h0, a[7:4]} * {4'h0, b[7:4]};
    exp_sc[0] = 2'b00; exp_sc[1] = 2'b01; exp_sc[2] = 2'b01; exp_sc[3] = 2'b10;
    sb.push_back(16'(a) * 16'(b));
    @(negedge clk);
    start = 1'b1; dataa = a; datab = b;
    @(negedge clk);
    if (hold) begin
      dataa = na; datab = nb;
    end else begin
      start = 1'b0; dataa = 8'($urandom); datab = 8'($urandom);
    end
    n = 1; seen = 0;
    while (!seen && n <= 12) begin
      if (n <= 4) begin
        chk($sformatf("shift_in[%0d]", n - 1), 32'(shift_in), 32'(exp_si[n - 1]));
        chk($sformatf("shift_cntrl[%0d]", n - 1), 32'(shift_cntrl), 32'(exp_sc[n - 1]));
        chk("busy_calc", 32'(busy), 32'd1);
      end
      if (done === 1'b1) seen = 1;
      else begin
        @(negedge clk);
        n++;
      end
    end
    start = 1'b0;
    chk("done_latency", n, LAT);
    exp_p = (sb.size() > 0) ? sb.pop_front() : 16'hxxxx;
    chk("product", 32'(product), 32'(exp_p));
    chk("busy_done", 32'(busy), 32'd0);
    chk("shift_cntrl_done", 32'(shift_cntrl), 32'd0);
    @(negedge clk);
    chk("done_pulse_clear", 32'(done), 32'd0);
    chk("product_held", 32'(product), 32'(exp_p));
    chk("shift_in_idle", 32'(shift_in), 32'd0);
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; dataa = '0; datab = '0;
    repeat (3) @(negedge clk);
    chk("rst_product", 32'(product), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle_shift_in", 32'(shift_in), 32'd0);
    chk("idle_shift_cntrl", 32'(shift_cntrl), 32'd0);

    run_op(8'h12, 8'h34, 1'b0, 8'h00, 8'h00);
    run_op(8'hFF, 8'hFF, 1'b0, 8'h00, 8'h00);
    run_op(8'h00, 8'hA5, 1'b0, 8'h00, 8'h00);
    // start held high with new operands during the operation is ignored
    run_op(8'h12, 8'h34, 1'b1, 8'h56, 8'h78);
    run_op(8'h56, 8'h78, 1'b0, 8'h00, 8'h00);

    // Reset applied at the edge that ends the cnt=2 cycle aborts the operation
    @(negedge clk);
    start = 1'b1; dataa = 8'hC3; datab = 8'h9D;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("mid_shift_cntrl_cnt2", 32'(shift_cntrl), 32'd1);
    rst_n = 1'b0;
    @(negedge clk);
    chk("abort_product", 32'(product), 32'd0);
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_done", 32'(done), 32'd0);
    chk("abort_shift_cntrl", 32'(shift_cntrl), 32'd0);
    chk("abort_shift_in", 32'(shift_in), 32'd0);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("post_abort_done", 32'(done), 32'd0);

    run_op(8'hA7, 8'h3C, 1'b0, 8'h00, 8'h00);
    run_op(8'h80, 8'h01, 1'b0, 8'h00, 8'h00);

    chk("scoreboard_empty", 32'(sb.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
